// File: rtl/axi_xbar_rr.sv
// AXI4 crossbar, NMST masters x NSLV slaves plus an internal decode-error target.
// Each target keeps its own round-robin arbiter and ownership state, so traffic
// to different targets proceeds concurrently with no added latency or buffering.
package axi_xbar_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int USER_W = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } axi4_metadata_type;

    typedef struct packed {
        logic              aw_valid;
        axi4_metadata_type aw_bits;
        logic [ID_W-1:0]   aw_id;
        logic [USER_W-1:0] aw_user;
        logic              w_valid;
        logic [DATA_W-1:0] w_data;
        logic [DATA_W/8-1:0] w_strb;
        logic              w_last;
        logic [USER_W-1:0] w_user;
        logic              b_ready;
        logic              ar_valid;
        axi4_metadata_type ar_bits;
        logic [ID_W-1:0]   ar_id;
        logic [USER_W-1:0] ar_user;
        logic              r_ready;
    } axi4_master_out_type;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic              b_valid;
        logic [1:0]        b_resp;
        logic [ID_W-1:0]   b_id;
        logic [USER_W-1:0] b_user;
        logic              ar_ready;
        logic              r_valid;
        logic [1:0]        r_resp;
        logic [DATA_W-1:0] r_data;
        logic              r_last;
        logic [ID_W-1:0]   r_id;
        logic [USER_W-1:0] r_user;
    } axi4_master_in_type;

    typedef axi4_master_out_type axi4_slave_in_type;
    typedef axi4_master_in_type  axi4_slave_out_type;

    typedef struct packed {
        logic [ADDR_W-1:0] addr_start;
        logic [ADDR_W-1:0] addr_end;
    } mapinfo_type;

    localparam axi4_master_out_type axi4_master_out_none = '0;
    localparam axi4_master_in_type  axi4_master_in_none  = '0;
    localparam axi4_slave_in_type   axi4_slave_in_none   = '0;
    localparam axi4_slave_out_type  axi4_slave_out_none  = '0;
    localparam mapinfo_type         mapinfo_none         = '0;
endpackage

module axi_xbar_rr
    import axi_xbar_pkg::*;
#(
    parameter int NMST = 2,
    parameter int NSLV = 4,
    parameter mapinfo_type [NSLV-1:0] MAP = {NSLV{mapinfo_none}}
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  axi4_master_out_type [NMST-1:0]      i_xmsto,
    output axi4_master_in_type  [NMST-1:0]      o_xmsti,
    input  axi4_slave_out_type  [NSLV-1:0]      i_xslvo,
    output axi4_slave_in_type   [NSLV-1:0]      o_xslvi,
    output mapinfo_type         [NSLV-1:0]      o_mapinfo
);
    localparam int T   = NSLV + 1;
    localparam int ERR = NSLV;
    localparam int MW  = (NMST > 1) ? $clog2(NMST) : 1;
    localparam int TW  = $clog2(NSLV + 1);

    typedef enum logic       {R_IDLE, R_BUSY}         rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    rstate_t            r_state [T];
    logic [MW-1:0]      r_owner [T];
    logic [MW-1:0]      rr_rd   [T];
    wstate_t            w_state [T];
    logic [MW-1:0]      w_owner [T];
    logic [MW-1:0]      rr_wr   [T];
    logic [NMST-1:0]    rd_busy;
    logic [NMST-1:0]    wr_busy;

    logic [TW-1:0]      ar_dec [NMST];
    logic [TW-1:0]      aw_dec [NMST];
    logic [T-1:0]       ar_gvld, aw_gvld;
    logic [MW-1:0]      ar_gnt [T];
    logic [MW-1:0]      aw_gnt [T];
    logic [T-1:0]       ar_fire, r_fire, aw_fire, w_fire, b_fire;
    axi4_slave_out_type tgt_rsp [T];

    logic [7:0]         err_rcnt;
    logic [ID_W-1:0]    err_rid, err_bid;
    logic [USER_W-1:0]  err_ruser, err_buser;

    // Lowest matching window wins; no match selects the error target.
    function automatic logic [TW-1:0] decode(input logic [ADDR_W-1:0] addr);
        logic [TW-1:0] tgt;
        tgt = TW'(ERR);
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (MAP[i].addr_start[ADDR_W-1:12] <= addr[ADDR_W-1:12] &&
                addr[ADDR_W-1:12] < MAP[i].addr_end[ADDR_W-1:12]) begin
                tgt = TW'(i);
            end
        end
        return tgt;
    endfunction

    assign o_mapinfo = MAP;

    // Decode every master request and pick one idle-target winner round-robin.
    always_comb begin
        logic [MW-1:0] ridx;
        logic [MW-1:0] widx;
        ridx = '0;
        widx = '0;
        for (int m = 0; m < NMST; m++) begin
            ar_dec[m] = decode(i_xmsto[m].ar_bits.addr);
            aw_dec[m] = decode(i_xmsto[m].aw_bits.addr);
        end
        for (int t = 0; t < T; t++) begin
            ar_gvld[t] = 1'b0;
            ar_gnt[t]  = '0;
            aw_gvld[t] = 1'b0;
            aw_gnt[t]  = '0;
            for (int k = 1; k <= NMST; k++) begin
                ridx = MW'((int'(rr_rd[t]) + k) % NMST);
                widx = MW'((int'(rr_wr[t]) + k) % NMST);
                if (!ar_gvld[t] && r_state[t] == R_IDLE && i_xmsto[ridx].ar_valid &&
                    !rd_busy[ridx] && ar_dec[ridx] == TW'(t)) begin
                    ar_gvld[t] = 1'b1;
                    ar_gnt[t]  = ridx;
                end
                if (!aw_gvld[t] && w_state[t] == W_IDLE && i_xmsto[widx].aw_valid &&
                    !wr_busy[widx] && aw_dec[widx] == TW'(t)) begin
                    aw_gvld[t] = 1'b1;
                    aw_gnt[t]  = widx;
                end
            end
        end
    end

    // Collect target responses (real slaves plus error target) and form handshakes.
    always_comb begin
        for (int s = 0; s < NSLV; s++) begin
            tgt_rsp[s] = i_xslvo[s];
        end
        tgt_rsp[ERR]          = axi4_slave_out_none;
        tgt_rsp[ERR].ar_ready = 1'b1;
        tgt_rsp[ERR].aw_ready = 1'b1;
        tgt_rsp[ERR].w_ready  = (w_state[ERR] == W_DATA);
        tgt_rsp[ERR].b_valid  = (w_state[ERR] == W_RESP);
        tgt_rsp[ERR].b_resp   = 2'b11;
        tgt_rsp[ERR].b_id     = err_bid;
        tgt_rsp[ERR].b_user   = err_buser;
        tgt_rsp[ERR].r_valid  = (r_state[ERR] == R_BUSY);
        tgt_rsp[ERR].r_resp   = 2'b11;
        tgt_rsp[ERR].r_data   = '1;
        tgt_rsp[ERR].r_last   = (err_rcnt == 8'd0);
        tgt_rsp[ERR].r_id     = err_rid;
        tgt_rsp[ERR].r_user   = err_ruser;
        for (int t = 0; t < T; t++) begin
            ar_fire[t] = ar_gvld[t] && tgt_rsp[t].ar_ready;
            aw_fire[t] = aw_gvld[t] && tgt_rsp[t].aw_ready;
            r_fire[t]  = (r_state[t] == R_BUSY) && tgt_rsp[t].r_valid &&
                         i_xmsto[r_owner[t]].r_ready;
            w_fire[t]  = (w_state[t] == W_DATA) && tgt_rsp[t].w_ready &&
                         i_xmsto[w_owner[t]].w_valid;
            b_fire[t]  = (w_state[t] == W_RESP) && tgt_rsp[t].b_valid &&
                         i_xmsto[w_owner[t]].b_ready;
        end
    end

    // Steer granted requests to slaves and owned responses back to masters.
    always_comb begin
        for (int m = 0; m < NMST; m++) begin
            o_xmsti[m] = axi4_master_in_none;
        end
        for (int s = 0; s < NSLV; s++) begin
            o_xslvi[s] = axi4_slave_in_none;
            if (ar_gvld[s]) begin
                o_xslvi[s].ar_valid = 1'b1;
                o_xslvi[s].ar_bits  = i_xmsto[ar_gnt[s]].ar_bits;
                o_xslvi[s].ar_id    = i_xmsto[ar_gnt[s]].ar_id;
                o_xslvi[s].ar_user  = i_xmsto[ar_gnt[s]].ar_user;
            end
            if (aw_gvld[s]) begin
                o_xslvi[s].aw_valid = 1'b1;
                o_xslvi[s].aw_bits  = i_xmsto[aw_gnt[s]].aw_bits;
                o_xslvi[s].aw_id    = i_xmsto[aw_gnt[s]].aw_id;
                o_xslvi[s].aw_user  = i_xmsto[aw_gnt[s]].aw_user;
            end
            if (w_state[s] == W_DATA) begin
                o_xslvi[s].w_valid = i_xmsto[w_owner[s]].w_valid;
                o_xslvi[s].w_data  = i_xmsto[w_owner[s]].w_data;
                o_xslvi[s].w_strb  = i_xmsto[w_owner[s]].w_strb;
                o_xslvi[s].w_last  = i_xmsto[w_owner[s]].w_last;
                o_xslvi[s].w_user  = i_xmsto[w_owner[s]].w_user;
            end
            if (w_state[s] == W_RESP) begin
                o_xslvi[s].b_ready = i_xmsto[w_owner[s]].b_ready;
            end
            if (r_state[s] == R_BUSY) begin
                o_xslvi[s].r_ready = i_xmsto[r_owner[s]].r_ready;
            end
        end
        for (int t = 0; t < T; t++) begin
            if (ar_gvld[t]) begin
                o_xmsti[ar_gnt[t]].ar_ready = tgt_rsp[t].ar_ready;
            end
            if (aw_gvld[t]) begin
                o_xmsti[aw_gnt[t]].aw_ready = tgt_rsp[t].aw_ready;
            end
            if (w_state[t] == W_DATA) begin
                o_xmsti[w_owner[t]].w_ready = tgt_rsp[t].w_ready;
            end
            if (w_state[t] == W_RESP) begin
                o_xmsti[w_owner[t]].b_valid = tgt_rsp[t].b_valid;
                o_xmsti[w_owner[t]].b_resp  = tgt_rsp[t].b_resp;
                o_xmsti[w_owner[t]].b_id    = tgt_rsp[t].b_id;
                o_xmsti[w_owner[t]].b_user  = tgt_rsp[t].b_user;
            end
            if (r_state[t] == R_BUSY) begin
                o_xmsti[r_owner[t]].r_valid = tgt_rsp[t].r_valid;
                o_xmsti[r_owner[t]].r_resp  = tgt_rsp[t].r_resp;
                o_xmsti[r_owner[t]].r_data  = tgt_rsp[t].r_data;
                o_xmsti[r_owner[t]].r_last  = tgt_rsp[t].r_last;
                o_xmsti[r_owner[t]].r_id    = tgt_rsp[t].r_id;
                o_xmsti[r_owner[t]].r_user  = tgt_rsp[t].r_user;
            end
        end
    end

    // Read ownership per target; a master stays busy until its last beat fires.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < T; t++) begin
                r_state[t] <= R_IDLE;
                r_owner[t] <= '0;
                rr_rd[t]   <= MW'(NMST - 1);
            end
            rd_busy <= '0;
        end else begin
            for (int t = 0; t < T; t++) begin
                case (r_state[t])
                    R_IDLE: if (ar_fire[t]) begin
                        r_state[t]          <= R_BUSY;
                        r_owner[t]          <= ar_gnt[t];
                        rr_rd[t]            <= ar_gnt[t];
                        rd_busy[ar_gnt[t]]  <= 1'b1;
                    end
                    R_BUSY: if (r_fire[t] && tgt_rsp[t].r_last) begin
                        r_state[t]          <= R_IDLE;
                        rd_busy[r_owner[t]] <= 1'b0;
                    end
                    default: r_state[t] <= R_IDLE;
                endcase
            end
        end
    end

    // Write ownership per target: address, data burst, then response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int t = 0; t < T; t++) begin
                w_state[t] <= W_IDLE;
                w_owner[t] <= '0;
                rr_wr[t]   <= MW'(NMST - 1);
            end
            wr_busy <= '0;
        end else begin
            for (int t = 0; t < T; t++) begin
                case (w_state[t])
                    W_IDLE: if (aw_fire[t]) begin
                        w_state[t]         <= W_DATA;
                        w_owner[t]         <= aw_gnt[t];
                        rr_wr[t]           <= aw_gnt[t];
                        wr_busy[aw_gnt[t]] <= 1'b1;
                    end
                    W_DATA: if (w_fire[t] && i_xmsto[w_owner[t]].w_last) begin
                        w_state[t] <= W_RESP;
                    end
                    W_RESP: if (b_fire[t]) begin
                        w_state[t]          <= W_IDLE;
                        wr_busy[w_owner[t]] <= 1'b0;
                    end
                    default: w_state[t] <= W_IDLE;
                endcase
            end
        end
    end

    // Error-target beat counter: loaded with arlen, counts down per beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_rcnt <= 8'd0;
        end else if (ar_fire[ERR]) begin
            err_rcnt <= i_xmsto[ar_gnt[ERR]].ar_bits.len;
        end else if (r_fire[ERR]) begin
            err_rcnt <= err_rcnt - 8'd1;
        end
    end

    // Error-target echo fields captured on address acceptance.
    always_ff @(posedge i_clk) begin
        if (ar_fire[ERR]) begin
            err_rid   <= i_xmsto[ar_gnt[ERR]].ar_id;
            err_ruser <= i_xmsto[ar_gnt[ERR]].ar_user;
        end
        if (aw_fire[ERR]) begin
            err_bid   <= i_xmsto[aw_gnt[ERR]].aw_id;
            err_buser <= i_xmsto[aw_gnt[ERR]].aw_user;
        end
    end
endmodule

// File: tb/tb_axi_xbar_rr.sv
// Directed bench for axi_xbar_rr: 2 masters, 4 slaves on 4 KB windows at
// 0x1000/0x2000/0x3000/0x4000, everything else decodes to the error target.
module tb_axi_xbar_rr;
    import axi_xbar_pkg::*;

    localparam logic [255:0] TB_MAP = {32'h0000_4000, 32'h0000_5000,
                                       32'h0000_3000, 32'h0000_4000,
                                       32'h0000_2000, 32'h0000_3000,
                                       32'h0000_1000, 32'h0000_2000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    axi4_master_out_type [1:0] xmsto;
    axi4_master_in_type  [1:0] xmsti;
    axi4_slave_out_type  [3:0] xslvo;
    axi4_slave_in_type   [3:0] xslvi;
    mapinfo_type         [3:0] mapinfo;

    int n_vec  = 0;
    int n_miss = 0;

    axi_xbar_rr #(.NMST(2), .NSLV(4), .MAP(TB_MAP)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_xmsto(xmsto), .o_xmsti(xmsti),
        .i_xslvo(xslvo), .o_xslvi(xslvi),
        .o_mapinfo(mapinfo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        xmsto = '0;
        xslvo = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic e;
        xmsto = '0;
        xslvo = '0;

        // ---- reset state and map output ----
        do_reset();
        xslvo[0].ar_ready = 1'b1;
        xslvo[0].aw_ready = 1'b1;
        xslvo[0].w_ready  = 1'b1;
        settle();
        chk("rst_m0_arready", xmsti[0].ar_ready, 0);
        chk("rst_m0_awready", xmsti[0].aw_ready, 0);
        chk("rst_m0_wready",  xmsti[0].w_ready, 0);
        chk("rst_s0_arvalid", xslvi[0].ar_valid, 0);
        chk("rst_m1_rvalid",  xmsti[1].r_valid, 0);
        chk("map2_start", mapinfo[2].addr_start, 32'h3000);
        chk("map2_end",   mapinfo[2].addr_end, 32'h4000);

        // ---- concurrent reads to slave 0 and slave 1 ----
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_bits.addr = 32'h1000;
        xmsto[0].ar_bits.len = 8'd3; xmsto[0].ar_id = 4'd1;
        xmsto[1].ar_valid = 1'b1; xmsto[1].ar_bits.addr = 32'h2000;
        xmsto[1].ar_bits.len = 8'd3; xmsto[1].ar_id = 4'd2;
        xslvo[1].ar_ready = 1'b1;
        settle();
        chk("conc_s0_arvalid", xslvi[0].ar_valid, 1);
        chk("conc_s0_arid",    xslvi[0].ar_id, 1);
        chk("conc_s1_arvalid", xslvi[1].ar_valid, 1);
        chk("conc_s1_arid",    xslvi[1].ar_id, 2);
        chk("conc_s0_len",     xslvi[0].ar_bits.len, 3);
        chk("conc_m0_arready", xmsti[0].ar_ready, 1);
        chk("conc_m1_arready", xmsti[1].ar_ready, 1);
        tick();
        xmsto[0].ar_valid = 1'b0;
        xmsto[1].ar_valid = 1'b0;
        xmsto[0].r_ready = 1'b1;
        xmsto[1].r_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            xslvo[0].r_valid = 1'b1; xslvo[0].r_data = 32'hA0 + k;
            xslvo[0].r_last = (k == 3); xslvo[0].r_id = 4'd1;
            xslvo[1].r_valid = 1'b1; xslvo[1].r_data = 32'hB0 + k;
            xslvo[1].r_last = (k == 3); xslvo[1].r_id = 4'd2;
            settle();
            chk("conc_m0_rdata", xmsti[0].r_data, 32'hA0 + k);
            chk("conc_m1_rdata", xmsti[1].r_data, 32'hB0 + k);
            chk("conc_m0_rlast", xmsti[0].r_last, (k == 3) ? 1 : 0);
            chk("conc_s0_rready", xslvi[0].r_ready, 1);
            tick();
        end
        settle();
        chk("conc_m0_done", xmsti[0].r_valid, 0);
        chk("conc_m1_done", xmsti[1].r_valid, 0);

        // ---- two masters streaming single-beat reads to slave 0 ----
        do_reset();
        xslvo[0].ar_ready = 1'b1;
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_bits.addr = 32'h1000; xmsto[0].ar_id = 4'd1;
        xmsto[1].ar_valid = 1'b1; xmsto[1].ar_bits.addr = 32'h1800; xmsto[1].ar_id = 4'd2;
        xmsto[0].r_ready = 1'b1;
        xmsto[1].r_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = i[0];
            xslvo[0].r_valid = 1'b0;
            settle();
            chk("alt_grant_id", xslvi[0].ar_id, e ? 2 : 1);
            chk("alt_other_rdy", xmsti[~e].ar_ready, 0);
            tick();
            xslvo[0].r_valid = 1'b1; xslvo[0].r_last = 1'b1;
            xslvo[0].r_id = e ? 4'd2 : 4'd1;
            settle();
            chk("alt_bubble", xmsti[0].ar_ready | xmsti[1].ar_ready, 0);
            chk("alt_route", xmsti[e].r_valid, 1);
            tick();
        end

        // ---- unmapped read and write go to the error target ----
        do_reset();
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_bits.addr = 32'hF000_0000;
        xmsto[0].ar_bits.len = 8'd7; xmsto[0].ar_id = 4'd5; xmsto[0].ar_user = 1'b1;
        xslvo[0].ar_ready = 1'b1;
        settle();
        chk("err_arready", xmsti[0].ar_ready, 1);
        chk("err_no_slave", xslvi[0].ar_valid | xslvi[1].ar_valid |
                            xslvi[2].ar_valid | xslvi[3].ar_valid, 0);
        tick();
        xmsto[0].ar_valid = 1'b0;
        settle();
        chk("err_stall_valid", xmsti[0].r_valid, 1);
        chk("err_stall_last",  xmsti[0].r_last, 0);
        tick();
        xmsto[0].r_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("err_rvalid", xmsti[0].r_valid, 1);
            chk("err_rresp",  xmsti[0].r_resp, 2'b11);
            chk("err_rdata",  xmsti[0].r_data, 32'hFFFF_FFFF);
            chk("err_rlast",  xmsti[0].r_last, (k == 7) ? 1 : 0);
            chk("err_rid",    xmsti[0].r_id, 5);
            chk("err_ruser",  xmsti[0].r_user, 1);
            tick();
        end
        settle();
        chk("err_rdone", xmsti[0].r_valid, 0);
        xmsto[1].aw_valid = 1'b1; xmsto[1].aw_bits.addr = 32'hF000_0000; xmsto[1].aw_id = 4'd6;
        settle();
        chk("errw_awready", xmsti[1].aw_ready, 1);
        tick();
        xmsto[1].aw_valid = 1'b0;
        xmsto[1].w_valid = 1'b1; xmsto[1].w_last = 1'b1;
        settle();
        chk("errw_wready", xmsti[1].w_ready, 1);
        tick();
        xmsto[1].w_valid = 1'b0;
        xmsto[1].b_ready = 1'b1;
        settle();
        chk("errw_bvalid", xmsti[1].b_valid, 1);
        chk("errw_bresp",  xmsti[1].b_resp, 2'b11);
        chk("errw_bid",    xmsti[1].b_id, 6);
        tick();
        settle();
        chk("errw_bdone", xmsti[1].b_valid, 0);

        // ---- write contention at slave 2 with a delayed response ----
        do_reset();
        xslvo[2].aw_ready = 1'b1;
        xslvo[2].w_ready = 1'b1;
        xmsto[1].aw_valid = 1'b1; xmsto[1].aw_bits.addr = 32'h3000;
        xmsto[1].aw_bits.len = 8'd1; xmsto[1].aw_id = 4'd3;
        settle();
        chk("wr_m1_awready", xmsti[1].aw_ready, 1);
        chk("wr_s2_awid",    xslvi[2].aw_id, 3);
        tick();
        xmsto[1].aw_valid = 1'b0;
        xmsto[1].w_valid = 1'b1; xmsto[1].w_data = 32'h11; xmsto[1].w_last = 1'b0;
        xmsto[0].aw_valid = 1'b1; xmsto[0].aw_bits.addr = 32'h3000; xmsto[0].aw_id = 4'd4;
        xmsto[0].w_valid = 1'b1; xmsto[0].w_data = 32'h99; xmsto[0].w_last = 1'b1;
        settle();
        chk("wr_s2_wdata",    xslvi[2].w_data, 32'h11);
        chk("wr_m1_wready",   xmsti[1].w_ready, 1);
        chk("wr_m0_early_w",  xmsti[0].w_ready, 0);
        chk("wr_m0_held",     xmsti[0].aw_ready, 0);
        tick();
        xmsto[1].w_data = 32'h22; xmsto[1].w_last = 1'b1;
        settle();
        chk("wr_s2_wlast", xslvi[2].w_last, 1);
        chk("wr_m0_held",  xmsti[0].aw_ready, 0);
        tick();
        xmsto[1].w_valid = 1'b0;
        xmsto[1].b_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("wr_delay_held", xmsti[0].aw_ready, 0);
            chk("wr_delay_nob",  xmsti[1].b_valid, 0);
            tick();
        end
        xslvo[2].b_valid = 1'b1; xslvo[2].b_id = 4'd3; xslvo[2].b_resp = 2'b00;
        settle();
        chk("wr_m1_bvalid", xmsti[1].b_valid, 1);
        chk("wr_m1_bid",    xmsti[1].b_id, 3);
        chk("wr_s2_bready", xslvi[2].b_ready, 1);
        chk("wr_bfire_held", xmsti[0].aw_ready, 0);
        tick();
        xslvo[2].b_valid = 1'b0;
        settle();
        chk("wr_m0_awready", xmsti[0].aw_ready, 1);
        chk("wr_s2_awid_m0", xslvi[2].aw_id, 4);
        tick();

        // ---- outstanding read blocks a second read elsewhere ----
        do_reset();
        xslvo[0].ar_ready = 1'b1;
        xslvo[1].ar_ready = 1'b1;
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_bits.addr = 32'h1000; xmsto[0].ar_id = 4'd1;
        xmsto[0].r_ready = 1'b1;
        settle();
        chk("busy_first_rdy", xmsti[0].ar_ready, 1);
        tick();
        xmsto[0].ar_bits.addr = 32'h2000;
        settle();
        chk("busy_blocked", xmsti[0].ar_ready, 0);
        chk("busy_s1_quiet", xslvi[1].ar_valid, 0);
        tick();
        xslvo[0].r_valid = 1'b1; xslvo[0].r_last = 1'b1; xslvo[0].r_id = 4'd1;
        settle();
        chk("busy_last_blk", xmsti[0].ar_ready, 0);
        tick();
        xslvo[0].r_valid = 1'b0;
        settle();
        chk("busy_released", xmsti[0].ar_ready, 1);
        chk("busy_s1_arv",   xslvi[1].ar_valid, 1);
        tick();

        // ---- reset in the middle of a 4-beat read ----
        do_reset();
        xslvo[0].ar_ready = 1'b1;
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_bits.addr = 32'h1000;
        xmsto[0].ar_bits.len = 8'd3; xmsto[0].ar_id = 4'd1;
        xmsto[0].r_ready = 1'b1;
        tick();
        xmsto[0].ar_valid = 1'b0;
        xslvo[0].r_valid = 1'b1; xslvo[0].r_data = 32'h50; xslvo[0].r_last = 1'b0;
        tick();
        xslvo[0].r_data = 32'h51;
        rst = 1'b1;
        settle();
        chk("mid_beat2", xmsti[0].r_data, 32'h51);
        tick();
        rst = 1'b0;
        xmsto[0].ar_valid = 1'b1; xmsto[0].ar_id = 4'd1;
        xmsto[1].ar_valid = 1'b1; xmsto[1].ar_bits.addr = 32'h1000; xmsto[1].ar_id = 4'd2;
        settle();
        chk("mid_rvalid_drop", xmsti[0].r_valid, 0);
        chk("mid_rready_drop", xslvi[0].r_ready, 0);
        chk("mid_m0_grant",    xmsti[0].ar_ready, 1);
        chk("mid_m1_wait",     xmsti[1].ar_ready, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
